dff_share_arbiter: RTL and testbench

Round-robin arbiter that shares one n-bit DFF-style holding register among four requesters. A requester raises `req` with its data on `dinX`. The arbiter picks one winner, loads that data into the shared register, and holds ownership for a fixed number of cycles before re-arbitrating. It sits between requesting datapath units and the shared register stage, sequencing every load into it.

---
 rtl/dff_share_arbiter.sv | 112 +++++++++++
 tb/tb_dff_share_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter sharing one n-bit holding register among four requesters.
// A grant loads q on the request edge and owns it for HOLD cycles; requests and data are ignored while owned.
module dff_share_arbiter #(
    parameter int n    = 8,
    parameter int HOLD = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [n-1:0] din0,
    input  logic [n-1:0] din1,
    input  logic [n-1:0] din2,
    input  logic [n-1:0] din3,
    output logic [3:0]   gnt,
    output logic [3:0]   ack,
    output logic [n-1:0] q,
    output logic [1:0]   owner,
    output logic         busy
);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t       state, state_nxt;
    logic [1:0]   ptr, ptr_nxt;
    logic [7:0]   cnt, cnt_nxt;
    logic [3:0]   gnt_nxt, ack_nxt;
    logic [n-1:0] q_nxt;
    logic [1:0]   owner_nxt;
    logic         busy_nxt;

    logic         found;
    logic [1:0]   winner;
    logic [n-1:0] win_dat;

    // Scan starts at ptr and wraps through the 2-bit index space.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        for (int k = 0; k < 4; k++) begin
            if (!found && req[2'(ptr + 2'(k))]) begin
                found  = 1'b1;
                winner = 2'(ptr + 2'(k));
            end
        end
    end

    always_comb begin
        case (winner)
            2'd0:    win_dat = din0;
            2'd1:    win_dat = din1;
            2'd2:    win_dat = din2;
            default: win_dat = din3;
        endcase
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        ack_nxt   = 4'b0000;
        q_nxt     = q;
        owner_nxt = owner;
        busy_nxt  = busy;
        case (state)
            S_IDLE: begin
                if (found) begin
                    q_nxt     = win_dat;
                    gnt_nxt   = 4'b0001 << winner;
                    ack_nxt   = 4'b0001 << winner;
                    owner_nxt = winner;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = 8'(HOLD - 1);
                    state_nxt = S_HOLD;
                end
            end
            default: begin
                if (cnt != 8'd0) begin
                    cnt_nxt = cnt - 8'd1;
                end else begin
                    gnt_nxt   = 4'b0000;
                    busy_nxt  = 1'b0;
                    ptr_nxt   = owner + 2'd1;
                    state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ptr   <= 2'd0;
            cnt   <= 8'd0;
            gnt   <= 4'b0000;
            ack   <= 4'b0000;
            q     <= '0;
            owner <= 2'd0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            gnt   <= gnt_nxt;
            ack   <= ack_nxt;
            q     <= q_nxt;
            owner <= owner_nxt;
            busy  <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Bench for dff_share_arbiter: three instances (HOLD=1,2,3) driven by shared stimulus.
// Fixed vector table, directed corner sequences, then random traffic against a timestamp-based model.
module tb_dff_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] din [4];

    always #5 clk = ~clk;

    logic [3:0] gnt_o [3];
    logic [3:0] ack_o [3];
    logic [7:0] q_o   [3];
    logic [1:0] own_o [3];
    logic       busy_o[3];
    logic [18:0] obs  [3];

    dff_share_arbiter #(.n(8), .HOLD(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
        .gnt(gnt_o[0]), .ack(ack_o[0]), .q(q_o[0]), .owner(own_o[0]), .busy(busy_o[0]));
    dff_share_arbiter #(.n(8), .HOLD(2)) u2 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
        .gnt(gnt_o[1]), .ack(ack_o[1]), .q(q_o[1]), .owner(own_o[1]), .busy(busy_o[1]));
    dff_share_arbiter #(.n(8), .HOLD(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .din0(din[0]), .din1(din[1]), .din2(din[2]), .din3(din[3]),
        .gnt(gnt_o[2]), .ack(ack_o[2]), .q(q_o[2]), .owner(own_o[2]), .busy(busy_o[2]));

    assign obs[0] = {gnt_o[0], ack_o[0], q_o[0], own_o[0], busy_o[0]};
    assign obs[1] = {gnt_o[1], ack_o[1], q_o[1], own_o[1], busy_o[1]};
    assign obs[2] = {gnt_o[2], ack_o[2], q_o[2], own_o[2], busy_o[2]};

    int tests = 0;
    int fails = 0;

    function automatic logic [18:0] pk(logic [3:0] g, logic [3:0] a, logic [7:0] qv,
                                       logic [1:0] o, logic b);
        return {g, a, qv, o, b};
    endfunction

    task automatic check(input string name, input int h, input logic [18:0] exp);
        logic [18:0] got;
        got = obs[h];
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s (HOLD=%0d) t=%0t: got gnt=%b ack=%b q=%h owner=%0d busy=%b, want gnt=%b ack=%b q=%h owner=%0d busy=%b",
                     name, h + 1, $time, got[18:15], got[14:11], got[10:3], got[2:1], got[0],
                     exp[18:15], exp[14:11], exp[10:3], exp[2:1], exp[0]);
        end
    endtask

    // Reference model: a grant is an (owner, edge-number) pair; it lasts until HOLD edges have passed.
    int         ecount = 0;
    int         m_act [3];
    int         m_g   [3];
    int         m_ptr [3];
    int         m_own [3];
    logic [7:0] m_q   [3];

    task automatic model_step();
        int hold, best, bestd, d;
        ecount++;
        for (int h = 0; h < 3; h++) begin
            hold = h + 1;
            if (!rst_n) begin
                m_act[h] = 0; m_g[h] = -1000; m_ptr[h] = 0; m_own[h] = 0; m_q[h] = 8'h00;
            end else if (m_act[h] != 0) begin
                if (ecount - m_g[h] == hold) begin
                    m_act[h] = 0;
                    m_ptr[h] = (m_own[h] + 1) % 4;
                end
            end else if (req != 4'b0000) begin
                best = -1; bestd = 99;
                for (int i = 0; i < 4; i++) begin
                    d = (i - m_ptr[h] + 4) % 4;
                    if (req[i] && d < bestd) begin
                        bestd = d; best = i;
                    end
                end
                m_act[h] = 1; m_g[h] = ecount; m_own[h] = best; m_q[h] = din[best];
            end
        end
    endtask

    function automatic logic [18:0] model_exp(input int h);
        logic [3:0] g, a;
        g = (m_act[h] != 0) ? 4'(1 << m_own[h]) : 4'b0000;
        a = (m_act[h] != 0 && m_g[h] == ecount) ? g : 4'b0000;
        return pk(g, a, m_q[h], 2'(m_own[h]), m_act[h] != 0);
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_din(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] e);
        din[0] = a; din[1] = b; din[2] = c; din[3] = e;
    endtask

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic [18:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [3:0] rq, logic [18:0] e);
        vec_t v;
        v.rst_n = r; v.req = rq; v.exp = e;
        return v;
    endfunction

    logic [3:0] h1_gnt [6];
    logic [7:0] h1_q   [6];
    logic [1:0] h1_own [6];
    logic       h1_busy[6];

    initial begin
        // HOLD=2 vectors: reset, single requester with regrant, full round robin.
        tbl.push_back(mk(1'b0, 4'hF, pk(4'h0, 4'h0, 8'h00, 2'd0, 1'b0)));
        tbl.push_back(mk(1'b0, 4'hF, pk(4'h0, 4'h0, 8'h00, 2'd0, 1'b0)));
        tbl.push_back(mk(1'b1, 4'h4, pk(4'h4, 4'h4, 8'hA5, 2'd2, 1'b1)));
        tbl.push_back(mk(1'b1, 4'h4, pk(4'h4, 4'h0, 8'hA5, 2'd2, 1'b1)));
        tbl.push_back(mk(1'b1, 4'h4, pk(4'h0, 4'h0, 8'hA5, 2'd2, 1'b0)));
        tbl.push_back(mk(1'b1, 4'h4, pk(4'h4, 4'h4, 8'hA5, 2'd2, 1'b1)));
        tbl.push_back(mk(1'b1, 4'h4, pk(4'h4, 4'h0, 8'hA5, 2'd2, 1'b1)));
        tbl.push_back(mk(1'b1, 4'h0, pk(4'h0, 4'h0, 8'hA5, 2'd2, 1'b0)));
        tbl.push_back(mk(1'b0, 4'h0, pk(4'h0, 4'h0, 8'h00, 2'd0, 1'b0)));
        tbl.push_back(mk(1'b1, 4'hF, pk(4'h1, 4'h1, 8'h10, 2'd0, 1'b1)));
        tbl.push_back(mk(1'b1, 4'hF, pk(4'h1, 4'h0, 8'h10, 2'd0, 1'b1)));
        tbl.push_back(mk(1'b1, 4'hF, pk(4'h0, 4'h0, 8'h10, 2'd0, 1'b0)));
        tbl.push_back(mk(1'b1, 4'hF, pk(4'h2, 4'h2, 8'h21, 2'd1, 1'b1)));
        tbl.push_back(mk(1'b1, 4'hF, pk(4'h2, 4'h0, 8'h21, 2'd1, 1'b1)));
        tbl.push_back(mk(1'b1, 4'hF, pk(4'h0, 4'h0, 8'h21, 2'd1, 1'b0)));
        tbl.push_back(mk(1'b1, 4'hF, pk(4'h4, 4'h4, 8'hA5, 2'd2, 1'b1)));
        tbl.push_back(mk(1'b1, 4'hF, pk(4'h4, 4'h0, 8'hA5, 2'd2, 1'b1)));
        tbl.push_back(mk(1'b1, 4'hF, pk(4'h0, 4'h0, 8'hA5, 2'd2, 1'b0)));
        tbl.push_back(mk(1'b1, 4'hF, pk(4'h8, 4'h8, 8'h3F, 2'd3, 1'b1)));
        tbl.push_back(mk(1'b1, 4'hF, pk(4'h8, 4'h0, 8'h3F, 2'd3, 1'b1)));
        tbl.push_back(mk(1'b1, 4'hF, pk(4'h0, 4'h0, 8'h3F, 2'd3, 1'b0)));
        tbl.push_back(mk(1'b1, 4'hF, pk(4'h1, 4'h1, 8'h10, 2'd0, 1'b1)));
        tbl.push_back(mk(1'b1, 4'hF, pk(4'h1, 4'h0, 8'h10, 2'd0, 1'b1)));

        h1_gnt  = '{4'h1, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};
        h1_q    = '{8'h10, 8'h10, 8'h3F, 8'h3F, 8'h10, 8'h10};
        h1_own  = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd0};
        h1_busy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0;
        req   = 4'h0;
        set_din(8'h10, 8'h21, 8'hA5, 8'h3F);

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n;
            req   = tbl[i].req;
            tick();
            check($sformatf("vec%0d", i), 1, tbl[i].exp);
        end

        // Data isolation on HOLD=3: req drops and din changes while owned.
        rst_n = 1'b0; req = 4'h0; tick();
        rst_n = 1'b1; set_din(8'h10, 8'h11, 8'hA5, 8'h3F); req = 4'b0010; tick();
        check("iso_grant", 2, pk(4'h2, 4'h2, 8'h11, 2'd1, 1'b1));
        din[1] = 8'h3C; req = 4'h0; tick();
        check("iso_hold1", 2, pk(4'h2, 4'h0, 8'h11, 2'd1, 1'b1));
        tick();
        check("iso_hold2", 2, pk(4'h2, 4'h0, 8'h11, 2'd1, 1'b1));
        tick();
        check("iso_release", 2, pk(4'h0, 4'h0, 8'h11, 2'd1, 1'b0));

        // Reset mid-HOLD on HOLD=2 after steering ptr to 2.
        rst_n = 1'b0; req = 4'h0; tick();
        rst_n = 1'b1; set_din(8'h10, 8'h21, 8'hA5, 8'h3F); req = 4'b0010;
        tick(); tick(); tick();
        req = 4'b0100; tick();
        check("rmh_setup", 1, pk(4'h4, 4'h4, 8'hA5, 2'd2, 1'b1));
        rst_n = 1'b0; req = 4'b1010; tick();
        check("rmh_reset", 1, pk(4'h0, 4'h0, 8'h00, 2'd0, 1'b0));
        rst_n = 1'b1; tick();
        check("rmh_grant1", 1, pk(4'h2, 4'h2, 8'h21, 2'd1, 1'b1));
        tick();
        check("rmh_hold1", 1, pk(4'h2, 4'h0, 8'h21, 2'd1, 1'b1));
        tick();
        check("rmh_gap", 1, pk(4'h0, 4'h0, 8'h21, 2'd1, 1'b0));
        tick();
        check("rmh_grant3", 1, pk(4'h8, 4'h8, 8'h3F, 2'd3, 1'b1));

        // HOLD=1 with two continuous requesters: single-cycle grants, gnt equals ack.
        rst_n = 1'b0; req = 4'h0; tick();
        rst_n = 1'b1; req = 4'b1001;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("h1_cyc%0d", i), 0,
                  pk(h1_gnt[i], h1_gnt[i], h1_q[i], h1_own[i], h1_busy[i]));
        end

        // Random traffic with sporadic resets against the model.
        rst_n = 1'b0; req = 4'h0; tick();
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            req   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) din[i] = 8'($urandom_range(0, 255));
            tick();
            for (int h = 0; h < 3; h++) check($sformatf("rand%0d", c), h, model_exp(h));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
